// File: rtl/raycast_pkg.sv
// Shared definitions for the octree node fetcher.
// Holds the descriptor field layout and the fetch FSM state encoding.
package raycast_pkg;

  // Octree node descriptor layout
  localparam int CHILD_PTR_MSB = 31;
  localparam int CHILD_PTR_LSB = 17;
  localparam int FAR_BIT       = 16;
  localparam int VALID_MSB     = 15;
  localparam int VALID_LSB     = 8;
  localparam int LEAF_MSB      = 7;
  localparam int LEAF_LSB      = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CALC    = 3'd1,
    ST_FAR_RD  = 3'd2,
    ST_ADDR    = 3'd3,
    ST_DESC_RD = 3'd4,
    ST_RESP    = 3'd5
  } state_t;

endpackage

// File: rtl/raycast_node_fetch_if.sv
// Single-word Wishbone read port between the node fetcher and one core
// port of the shared raycast cache master.
//   adr : read byte address        (master -> slave)
//   cyc : bus cycle                (master -> slave)
//   stb : strobe, identical to cyc (master -> slave)
//   ack : one-cycle acknowledge    (slave -> master)
//   dat : read data                (slave -> master)
interface raycast_node_fetch_if #(
  parameter int ADR_W = 32
);
  logic [ADR_W-1:0] adr;
  logic             cyc;
  logic             stb;
  logic             ack;
  logic [ADR_W-1:0] dat;

  modport master (output adr, cyc, stb, input ack, dat);
  modport slave  (input adr, cyc, stb, output ack, dat);
endinterface

// File: rtl/raycast_popcnt8.sv
// Combinational population count of an 8-bit mask.
//   bits  : input mask
//   count : number of set bits, 0-8
module raycast_popcnt8 (
  input  logic [7:0] bits,
  output logic [3:0] count
);
  always_comb begin
    count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      count = count + {3'd0, bits[i]};
    end
  end
endmodule

// File: rtl/raycast_node_fetch.sv
// Per-core octree node fetcher. Takes a parent descriptor plus a child index,
// resolves the child address (following far pointers relative to the octree
// root) and reads the child descriptor over a single-word Wishbone port.
//   wb_clk, wb_rst      : clock, synchronous active-high reset
//   root_adr_i          : octree root byte address (far pointer base)
//   req_*               : parent node request, valid/ready handshake
//   rsp_*               : child result, valid/ready handshake
//   m_wb                : Wishbone read master toward the cache
//
// state   | meaning
// IDLE    | waiting for a request, req_ready_o high
// CALC    | check child existence, form near base or far pointer address
// FAR_RD  | reading the far pointer word
// ADDR    | add sibling offset, finish leaf or start descriptor read
// DESC_RD | reading the child descriptor
// RESP    | presenting the response until the core takes it
module raycast_node_fetch
  import raycast_pkg::*;
#(
  parameter int ADR_W    = 32,
  parameter int PTR_BITS = 15
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic [ADR_W-1:0] root_adr_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [ADR_W-1:0] req_node_adr_i,
  input  logic [ADR_W-1:0] req_desc_i,
  input  logic [2:0]       req_child_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [ADR_W-1:0] rsp_desc_o,
  output logic [ADR_W-1:0] rsp_adr_o,
  output logic             rsp_leaf_o,
  output logic             rsp_empty_o,
  raycast_node_fetch_if.master m_wb
);

  state_t state, state_nxt;

  logic [ADR_W-1:0]    node_q, base_q, adr_q, desc_q;
  logic [2:0]          child_q;
  logic                bus_q;
  logic [PTR_BITS-1:0] ptr;
  logic                far;
  logic [7:0]          valid_mask, leaf_mask, sib_mask;
  logic [3:0]          sib_cnt;
  logic [ADR_W-1:0]    near_base, far_base, child_adr;
  logic                child_valid, child_leaf, req_fire, rsp_fire;

  assign ptr         = desc_q[CHILD_PTR_LSB +: PTR_BITS];
  assign far         = desc_q[FAR_BIT];
  assign valid_mask  = desc_q[VALID_MSB:VALID_LSB];
  assign leaf_mask   = desc_q[LEAF_MSB:LEAF_LSB];
  assign child_valid = valid_mask[child_q];
  assign child_leaf  = leaf_mask[child_q];

  // Children are packed densely: offset = number of existing lower siblings.
  assign sib_mask  = valid_mask & ((8'd1 << child_q) - 8'd1);
  assign near_base = node_q + ADR_W'({ptr, 2'b00});
  assign far_base  = root_adr_i + {m_wb.dat[ADR_W-3:0], 2'b00};
  assign child_adr = base_q + ADR_W'({sib_cnt, 2'b00});

  assign req_fire = req_valid_i && req_ready_o;
  assign rsp_fire = rsp_valid_o && rsp_ready_i;

  raycast_popcnt8 u_popcnt (
    .bits  (sib_mask),
    .count (sib_cnt)
  );

  assign m_wb.adr = adr_q;
  assign m_wb.cyc = bus_q;
  assign m_wb.stb = bus_q;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (req_fire) state_nxt = ST_CALC;
      ST_CALC: begin
        if (!child_valid) state_nxt = ST_RESP;
        else if (far)     state_nxt = ST_FAR_RD;
        else              state_nxt = ST_ADDR;
      end
      ST_FAR_RD:  if (m_wb.ack) state_nxt = ST_ADDR;
      ST_ADDR:    state_nxt = child_leaf ? ST_RESP : ST_DESC_RD;
      ST_DESC_RD: if (m_wb.ack) state_nxt = ST_RESP;
      ST_RESP:    if (rsp_fire) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_desc_o  <= '0;
      rsp_adr_o   <= '0;
      rsp_leaf_o  <= 1'b0;
      rsp_empty_o <= 1'b0;
      node_q      <= '0;
      desc_q      <= '0;
      child_q     <= '0;
      base_q      <= '0;
      adr_q       <= '0;
      bus_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_fire) begin
            node_q      <= req_node_adr_i;
            desc_q      <= req_desc_i;
            child_q     <= req_child_i;
            req_ready_o <= 1'b0;
          end
        end
        ST_CALC: begin
          if (!child_valid) begin
            rsp_desc_o  <= '0;
            rsp_adr_o   <= '0;
            rsp_leaf_o  <= 1'b0;
            rsp_empty_o <= 1'b1;
          end else if (far) begin
            adr_q <= near_base;
            bus_q <= 1'b1;
          end else begin
            base_q <= near_base;
          end
        end
        ST_FAR_RD: begin
          if (m_wb.ack) begin
            bus_q  <= 1'b0;
            base_q <= far_base;
          end
        end
        ST_ADDR: begin
          if (child_leaf) begin
            rsp_desc_o  <= '0;
            rsp_adr_o   <= child_adr;
            rsp_leaf_o  <= 1'b1;
            rsp_empty_o <= 1'b0;
          end else begin
            adr_q <= child_adr;
            bus_q <= 1'b1;
          end
        end
        ST_DESC_RD: begin
          if (m_wb.ack) begin
            bus_q       <= 1'b0;
            rsp_desc_o  <= m_wb.dat;
            rsp_adr_o   <= adr_q;
            rsp_leaf_o  <= 1'b0;
            rsp_empty_o <= 1'b0;
          end
        end
        ST_RESP: begin
          // Valid rises on the first RESP cycle so the data is already settled.
          if (!rsp_valid_o) begin
            rsp_valid_o <= 1'b1;
          end else if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
          end
        end
        default: bus_q <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_raycast_node_fetch.sv
module tb_raycast_node_fetch;

  typedef struct packed {
    logic [31:0] desc;
    logic [31:0] adr;
    logic        leaf;
    logic        empty;
  } rsp_t;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [31:0] root_adr;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_node_adr;
  logic [31:0] req_desc;
  logic [2:0]  req_child;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_desc;
  logic [31:0] rsp_adr;
  logic        rsp_leaf;
  logic        rsp_empty;

  raycast_node_fetch_if wb ();

  raycast_node_fetch dut (
    .wb_clk         (wb_clk),
    .wb_rst         (wb_rst),
    .root_adr_i     (root_adr),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_node_adr_i (req_node_adr),
    .req_desc_i     (req_desc),
    .req_child_i    (req_child),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_desc_o     (rsp_desc),
    .rsp_adr_o      (rsp_adr),
    .rsp_leaf_o     (rsp_leaf),
    .rsp_empty_o    (rsp_empty),
    .m_wb           (wb)
  );

  always #5 wb_clk = ~wb_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int bus_viol = 0;
  int ack_dly = 1;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_q [$];
  rsp_t exp_q [$];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Reference behaviour of a child lookup, evaluated when the request is sent.
  function automatic rsp_t model(input logic [31:0] node, input logic [31:0] d,
                                 input logic [2:0] ch);
    rsp_t r;
    logic [7:0] vm, lm;
    logic [31:0] base;
    int cnt;
    r  = '0;
    vm = d[15:8];
    lm = d[7:0];
    if (!vm[ch]) begin
      r.empty = 1'b1;
      return r;
    end
    base = node + (32'(d[31:17]) << 2);
    if (d[16]) base = root_adr + (mem_rd(base) << 2);
    cnt = 0;
    for (int i = 0; i < 8; i++) if (i < int'(ch) && vm[i]) cnt++;
    r.adr = base + 32'(cnt) * 32'd4;
    if (lm[ch]) r.leaf = 1'b1;
    else        r.desc = mem_rd(r.adr);
    return r;
  endfunction

  // Wishbone slave: acks each read after ack_dly cycles of stb, logs addresses
  initial begin
    logic [31:0] a0;
    wb.ack = 1'b0;
    wb.dat = 32'h0;
    forever begin
      @(negedge wb_clk);
      if (wb.stb) begin
        a0 = wb.adr;
        for (int i = 1; i < ack_dly; i++) begin
          @(negedge wb_clk);
          if (wb.stb && wb.adr !== a0) bus_viol++;
        end
        wb.ack = 1'b1;
        wb.dat = mem_rd(a0);
        rd_q.push_back(a0);
        @(negedge wb_clk);
        wb.ack = 1'b0;
        if (wb.stb || wb.cyc) bus_viol++;
      end
    end
  end

  always @(negedge wb_clk) if (wb.cyc !== wb.stb) bus_viol++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_req(input logic [31:0] node, input logic [31:0] d,
                          input logic [2:0] ch, input bit push);
    if (push) exp_q.push_back(model(node, d, ch));
    @(negedge wb_clk);
    req_valid    = 1'b1;
    req_node_adr = node;
    req_desc     = d;
    req_child    = ch;
    @(posedge wb_clk);
    #1 req_valid = 1'b0;
  endtask

  // Counts negedges after the accept edge until rsp_valid is seen.
  task automatic wait_rsp(output int lat, output int first_stb, output int stb_cyc);
    lat = 0; first_stb = 0; stb_cyc = 0;
    while (rsp_valid !== 1'b1 && lat < 200) begin
      @(negedge wb_clk);
      lat++;
      if (wb.stb) begin
        stb_cyc++;
        if (first_stb == 0) first_stb = lat;
      end
    end
  endtask

  task automatic consume(input string name, input int hold);
    rsp_t e, got;
    n_cmp++;
    if (rsp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL %s timeout: rsp_valid=%b required 1", name, rsp_valid);
      return;
    end
    got = {rsp_desc, rsp_adr, rsp_leaf, rsp_empty};
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: response with empty scoreboard", name);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_bad++;
        $display("FAIL %s rsp: got desc=%h adr=%h leaf=%b empty=%b, required desc=%h adr=%h leaf=%b empty=%b",
                 name, got.desc, got.adr, got.leaf, got.empty, e.desc, e.adr, e.leaf, e.empty);
      end
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge wb_clk);
      n_cmp++;
      if ({rsp_valid, req_ready, rsp_desc, rsp_adr, rsp_leaf, rsp_empty} !== {2'b10, got}) begin
        n_bad++;
        $display("FAIL %s hold%0d: valid=%b req_ready=%b desc=%h adr=%h, required 1/0 desc=%h adr=%h",
                 name, i, rsp_valid, req_ready, rsp_desc, rsp_adr, got.desc, got.adr);
      end
    end
    @(negedge wb_clk);
    rsp_ready = 1'b1;
    @(posedge wb_clk);
    #1 rsp_ready = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s after handshake: rsp_valid=%b req_ready=%b, required 0/1",
               name, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    wb_rst = 1'b1;
    repeat (3) @(posedge wb_clk);
    @(negedge wb_clk);
    n_cmp++;
    if ({req_ready, rsp_valid, wb.cyc, wb.stb, wb.adr} !== {4'b1000, 32'h0}) begin
      n_bad++;
      $display("FAIL reset ctrl: ready=%b valid=%b cyc=%b stb=%b adr=%h, required 1 0 0 0 0",
               req_ready, rsp_valid, wb.cyc, wb.stb, wb.adr);
    end
    n_cmp++;
    if ({rsp_desc, rsp_adr, rsp_leaf, rsp_empty} !== 66'h0) begin
      n_bad++;
      $display("FAIL reset rsp: desc=%h adr=%h leaf=%b empty=%b, required all 0",
               rsp_desc, rsp_adr, rsp_leaf, rsp_empty);
    end
    wb_rst = 1'b0;
  endtask

  task automatic test_near();
    int lat, fs, sc;
    mem[32'h1018] = 32'hDEADBEEF;
    ack_dly = 1;
    rd_q.delete();
    send_req(32'h1000, 32'h0006B501, 3'd5, 1'b1);
    wait_rsp(lat, fs, sc);
    n_cmp++;
    if (lat != 5 || fs != 3 || sc != 1) begin
      n_bad++;
      $display("FAIL near timing: rsp at %0d stb at %0d stb_cycles %0d, required 5 3 1", lat, fs, sc);
    end
    consume("near", 0);
    n_cmp++;
    if (rd_q.size() != 1 || rd_q[0] !== 32'h1018) begin
      n_bad++;
      $display("FAIL near reads: count=%0d first=%h, required 1 at 00001018",
               rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 32'hx);
    end
  endtask

  task automatic test_empty();
    int lat, fs, sc;
    rd_q.delete();
    send_req(32'h1000, 32'h0006B501, 3'd1, 1'b1);
    wait_rsp(lat, fs, sc);
    n_cmp++;
    if (lat != 3 || sc != 0 || rd_q.size() != 0) begin
      n_bad++;
      $display("FAIL empty timing: rsp at %0d stb_cycles %0d reads %0d, required 3 0 0",
               lat, sc, rd_q.size());
    end
    consume("empty", 0);
  endtask

  task automatic test_far();
    int lat, fs, sc;
    mem[32'h1008] = 32'h00000040;
    mem[32'h811C] = 32'hCAFEF00D;
    ack_dly = 1;
    rd_q.delete();
    send_req(32'h1000, 32'h0005FF00, 3'd7, 1'b1);
    wait_rsp(lat, fs, sc);
    consume("far", 0);
    n_cmp++;
    if (rd_q.size() != 2 || rd_q[0] !== 32'h1008 || rd_q[1] !== 32'h811C) begin
      n_bad++;
      $display("FAIL far reads: count=%0d, required 2 reads at 00001008 then 0000811c", rd_q.size());
    end
    n_cmp++;
    if (fs != 2 || sc != 2) begin
      n_bad++;
      $display("FAIL far bus: stb at %0d stb_cycles %0d, required 2 2", fs, sc);
    end
  endtask

  task automatic test_leaf();
    int lat, fs, sc;
    rd_q.delete();
    send_req(32'h1000, 32'h0006B520, 3'd5, 1'b1);
    wait_rsp(lat, fs, sc);
    n_cmp++;
    if (lat != 4 || rd_q.size() != 0) begin
      n_bad++;
      $display("FAIL leaf timing: rsp at %0d reads %0d, required 4 0", lat, rd_q.size());
    end
    consume("leaf", 0);
  endtask

  task automatic test_backpressure();
    int lat, fs, sc;
    ack_dly = 5;
    rd_q.delete();
    send_req(32'h1000, 32'h0006B501, 3'd5, 1'b1);
    wait_rsp(lat, fs, sc);
    n_cmp++;
    if (sc != 5 || fs != 3 || lat != 9) begin
      n_bad++;
      $display("FAIL slow ack: stb_cycles %0d stb at %0d rsp at %0d, required 5 3 9", sc, fs, lat);
    end
    consume("backpressure", 4);
    ack_dly = 1;
  endtask

  task automatic test_reset_mid();
    int n, lat, fs, sc;
    ack_dly = 8;
    send_req(32'h1000, 32'h0006B501, 3'd5, 1'b0);
    n = 0;
    while (wb.stb !== 1'b1 && n < 20) begin
      @(negedge wb_clk);
      n++;
    end
    n_cmp++;
    if (wb.stb !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid setup: stb=%b, required 1", wb.stb);
    end
    wb_rst = 1'b1;
    @(posedge wb_clk);
    #1;
    n_cmp++;
    if ({wb.cyc, wb.stb, req_ready, rsp_valid} !== 4'b0010) begin
      n_bad++;
      $display("FAIL reset_mid abort: cyc=%b stb=%b ready=%b valid=%b, required 0 0 1 0",
               wb.cyc, wb.stb, req_ready, rsp_valid);
    end
    @(negedge wb_clk);
    wb_rst = 1'b0;
    repeat (12) @(negedge wb_clk);
    n_cmp++;
    if ({wb.cyc, req_ready, rsp_valid} !== 3'b010) begin
      n_bad++;
      $display("FAIL late ack: cyc=%b ready=%b valid=%b, required 0 1 0",
               wb.cyc, req_ready, rsp_valid);
    end
    ack_dly = 1;
    rd_q.delete();
    send_req(32'h1000, 32'h0006B501, 3'd5, 1'b1);
    wait_rsp(lat, fs, sc);
    consume("after_reset", 1);
  endtask

  task automatic test_back_to_back();
    int lat, fs, sc;
    logic [31:0] node, d;
    for (int k = 0; k < 10; k++) begin
      node = 32'h1000 + (32'($urandom_range(0, 511)) << 2);
      d = $urandom;
      d[31:17] = 15'($urandom_range(0, 255));
      ack_dly = $urandom_range(1, 3);
      send_req(node, d, 3'($urandom_range(0, 7)), 1'b1);
      wait_rsp(lat, fs, sc);
      consume($sformatf("b2b%0d", k), $urandom_range(0, 2));
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard drain: %0d left, required 0", exp_q.size());
    end
    n_cmp++;
    if (bus_viol != 0) begin
      n_bad++;
      $display("FAIL bus rules: %0d violations, required 0", bus_viol);
    end
  endtask

  initial begin
    root_adr     = 32'h8000;
    req_valid    = 1'b0;
    req_node_adr = 32'h0;
    req_desc     = 32'h0;
    req_child    = 3'd0;
    rsp_ready    = 1'b0;
    wb_rst       = 1'b1;
    for (int a = 0; a < 4096; a++) mem[32'(a * 4)] = $urandom;
    test_reset();
    test_near();
    test_empty();
    test_far();
    test_leaf();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
